// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the 4-bit-opcode CPU: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over one shared memory port guarded by a request timeout.
module mc_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic [1:0] o_pc_src,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_alusrc,
  output logic [2:0] o_alucontrol,
  output logic       o_instr_done,
  output logic       o_illegal_op,
  output logic       o_halted
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Opcode map: 0000..0110 are R-type with alucontrol = op[2:0].
  localparam logic [3:0] OP_RMAX = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_LD   = 4'b1001;
  localparam logic [3:0] OP_ST   = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_NOP  = 4'b1100;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_expired;

  assign w_expired = (r_wait_cnt == LAST_WAIT);

  // State and wait counter; the counter restarts whenever a new request phase begins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_RST;
      r_wait_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) begin
        r_wait_cnt <= {CNT_W{1'b0}};
      end else if (o_mem_req && !i_mem_ready) begin
        r_wait_cnt <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end
  end

  // Next-state and output decode from state, opcode and the handshake inputs.
  always_comb begin
    w_next       = r_state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_iord       = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_pc_src     = 2'b00;
    o_regwrite   = 1'b0;
    o_regdst     = 1'b0;
    o_memtoreg   = 1'b0;
    o_alusrc     = 1'b0;
    o_alucontrol = 3'b000;
    o_instr_done = 1'b0;
    o_illegal_op = 1'b0;
    o_halted     = 1'b0;
    case (r_state)
      S_RST: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_we = 1'b1;
          o_pc_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_expired) begin
          w_next = S_HALT;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (i_op == OP_JMP) begin
          o_pc_we      = 1'b1;
          o_pc_src     = 2'b10;
          o_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else if (i_op == OP_NOP) begin
          o_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else if (i_op > OP_NOP) begin
          o_illegal_op = 1'b1;
          o_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_op <= OP_RMAX) begin
          o_alucontrol = i_op[2:0];
          w_next       = S_WB;
        end else if (i_op == OP_ADDI) begin
          o_alusrc = 1'b1;
          w_next   = S_WB;
        end else if ((i_op == OP_LD) || (i_op == OP_ST)) begin
          o_alusrc = 1'b1;
          w_next   = S_MEM;
        end else if (i_op == OP_BNE) begin
          o_alucontrol = 3'b111;
          o_instr_done = 1'b1;
          w_next       = S_FETCH;
          if (!i_zero) begin
            o_pc_we  = 1'b1;
            o_pc_src = 2'b01;
          end else begin
            o_pc_we  = 1'b0;
          end
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
        o_alusrc  = 1'b1;
        o_mem_we  = (i_op == OP_ST);
        if (i_mem_ready) begin
          if (i_op == OP_ST) begin
            o_instr_done = 1'b1;
            w_next       = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_expired) begin
          w_next = S_HALT;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        o_regwrite   = 1'b1;
        o_instr_done = 1'b1;
        o_regdst     = (i_op <= OP_RMAX);
        o_memtoreg   = (i_op == OP_LD);
        w_next       = S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
        w_next   = S_HALT;
      end
      default: begin
        w_next = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: a driver plays IR and memory, a monitor
// summarises each retired instruction and compares it with a queued reference record.
module tb_mc_ctrl;
  localparam int TMO  = 4;
  localparam int NINS = 250;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [3:0] op;
  logic       mem_req, mem_we, iord, ir_we, pc_we, regwrite, regdst, memtoreg, alusrc;
  logic       instr_done, illegal_op, halted;
  logic [1:0] pc_src;
  logic [2:0] alucontrol;

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord), .o_ir_we(ir_we),
    .o_pc_we(pc_we), .o_pc_src(pc_src), .o_regwrite(regwrite), .o_regdst(regdst),
    .o_memtoreg(memtoreg), .o_alusrc(alusrc), .o_alucontrol(alucontrol),
    .o_instr_done(instr_done), .o_illegal_op(illegal_op), .o_halted(halted)
  );

  wire [16:0] outs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, regwrite, regdst,
                      memtoreg, alusrc, alucontrol, instr_done, illegal_op, halted};

  typedef struct {
    int op, cyc, rw, rd, mtr, dm, we, pcb, src, ill, alu, asrc, hlt;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  function automatic rec_t blank();
    rec_t r;
    r.op = 0; r.cyc = 0; r.rw = 0; r.rd = 0; r.mtr = 0; r.dm = 0; r.we = 0;
    r.pcb = 0; r.src = 0; r.ill = 0; r.alu = 0; r.asrc = 0; r.hlt = 0;
    return r;
  endfunction

  // Reference: what one instruction should look like end to end, from the ISA rules.
  function automatic rec_t model(int o, int z, int wf, int wm);
    rec_t r = blank();
    r.op = o;
    case (o)
      0, 1, 2, 3, 4, 5, 6: begin   // ADD OR AND XOR NOR ROT SLL
        r.cyc = 4 + wf; r.rw = 1; r.rd = 1; r.alu = o;
      end
      7:  begin r.cyc = 4 + wf; r.rw = 1; r.alu = 0; r.asrc = 1; end           // ADDI
      8:  begin                                                                 // BNE
        r.cyc = 3 + wf; r.alu = 7;
        if (z == 0) begin r.pcb = 1; r.src = 1; end
      end
      9:  begin r.cyc = 5 + wf + wm; r.rw = 1; r.mtr = 1; r.dm = wm + 1; r.asrc = 1; end
      10: begin r.cyc = 4 + wf + wm; r.dm = wm + 1; r.we = wm + 1; r.asrc = 1; end
      11: begin r.cyc = 2 + wf; r.pcb = 1; r.src = 2; end                       // JMP
      12: begin r.cyc = 2 + wf; end                                             // NOP
      default: begin r.cyc = 2 + wf; r.ill = 1; end
    endcase
    return r;
  endfunction

  function automatic string fmt(rec_t r);
    return $sformatf("cyc=%0d rw=%0d rd=%0d mtr=%0d dmem=%0d we=%0d pcb=%0d src=%0d ill=%0d alu=%0d asrc=%0d hlt=%0d",
                     r.cyc, r.rw, r.rd, r.mtr, r.dm, r.we, r.pcb, r.src, r.ill, r.alu, r.asrc, r.hlt);
  endfunction

  function automatic bit rec_eq(rec_t a, rec_t b);
    return a.cyc == b.cyc && a.rw == b.rw && a.rd == b.rd && a.mtr == b.mtr &&
           a.dm == b.dm && a.we == b.we && a.pcb == b.pcb && a.src == b.src &&
           a.ill == b.ill && a.alu == b.alu && a.asrc == b.asrc && a.hlt == b.hlt;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Monitor: accumulate one instruction's observable behaviour, compare on retire.
  initial begin
    rec_t ob;
    int   k;
    bit   af;
    int   nret;
    ob = blank(); k = 0; af = 1'b0; nret = 0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        ob.cyc++;
        if (ir_we) begin af = 1'b1; k = 0; end
        else if (af) k++;
        if (regwrite) begin ob.rw++; ob.rd = regdst; ob.mtr = memtoreg; end
        if (mem_req && iord) ob.dm++;
        if (mem_we) ob.we++;
        if (pc_we && !ir_we) begin ob.pcb++; ob.src = pc_src; end
        if (illegal_op) ob.ill++;
        if (halted) ob.hlt++;
        if (af && k == 2) begin ob.alu = alucontrol; ob.asrc = alusrc; end
        if (instr_done) begin
          rec_t ex;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL retire[%0d]: unexpected retire, got %s, expected none", nret, fmt(ob));
          end else begin
            ex = exp_q.pop_front();
            if (!rec_eq(ob, ex)) begin
              n_fail++;
              $display("FAIL retire[%0d] op=%0d: got %s", nret, ex.op, fmt(ob));
              $display("     retire[%0d] op=%0d: expected %s", nret, ex.op, fmt(ex));
            end
          end
          nret++;
          ob = blank(); k = 0; af = 1'b0;
        end
      end
    end
  end

  // Driver: reset, random instruction stream, timeout, reset mid-access, expiry boundary.
  initial begin
    int  nop, nz, wf, wm, cf, cm, n;
    bit  done;
    rst_n = 1'b0; op = 4'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("fetch_after_reset", {29'd0, mem_req, iord, mem_we}, 32'd4);
    mon_en = 1'b1;

    for (int i = 0; i < NINS; i++) begin
      nop = $urandom_range(0, 15); nz = $urandom_range(0, 1);
      wf  = $urandom_range(0, TMO - 1); wm = $urandom_range(0, TMO - 1);
      cf  = 0; cm = 0;
      exp_q.push_back(model(nop, nz, wf, wm));
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        if (mem_req && !iord) begin
          if (cf == wf) begin mem_ready = 1'b1; op = 4'(nop); zero = nz[0]; end
          else begin mem_ready = 1'b0; cf++; end
        end else if (mem_req && iord) begin
          if (cm == wm) mem_ready = 1'b1;
          else begin mem_ready = 1'b0; cm++; end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        #1 done = instr_done;
        @(negedge clk);
      end
      if (!done) begin
        check("retire_within_budget", 32'd0, 32'd1);
        finish_run();
      end
    end
    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Fetch never acknowledged: exactly TMO request cycles, then sticky halt.
    n = 0;
    for (int c = 0; c < 20 && !halted; c++) begin
      mem_ready = 1'b0;
      #1 if (mem_req) n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(n), 32'(TMO));
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1 check("halt_outputs", 32'(outs), 32'd1);
      @(negedge clk);
    end

    rst_n = 1'b0;
    @(negedge clk);
    #1 check("reset_from_halt", 32'(outs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1; op = 4'b1010;
    #1 check("fetch_st", {27'd0, mem_req, iord, mem_we, ir_we, pc_we}, 32'b10011);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("decode_st", 32'(outs), 32'd0);
    @(negedge clk);
    #1 check("exec_st", {27'd0, mem_req, alusrc, alucontrol}, 32'b01000);
    @(negedge clk);
    #1 check("mem_st", {27'd0, mem_req, mem_we, iord, regwrite, instr_done}, 32'b11100);
    rst_n = 1'b0;
    @(negedge clk);
    #1 check("reset_mid_mem", 32'(outs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("fetch_resume", {29'd0, mem_req, iord, mem_we}, 32'd4);

    // Ready arriving in the expiry cycle completes the fetch normally.
    for (int c = 0; c < TMO - 1; c++) begin
      mem_ready = 1'b0;
      @(negedge clk);
    end
    mem_ready = 1'b1; op = 4'b1100;
    #1 check("expiry_cycle_ready", {29'd0, ir_we, pc_we, halted}, 32'b110);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("expiry_then_nop", {29'd0, instr_done, halted, mem_req}, 32'b100);

    finish_run();
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the 4-bit-opcode CPU datapath. It replaces single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB, so one memory port can serve both instruction fetch and LD/ST. It sits between the instruction register, PC, register file, ALU and the shared memory port. Memory accesses use a req/ready handshake with a timeout.

Parameters:
TIMEOUT, 255, maximum cycles a memory request may wait for mem_ready before the FSM halts (legal range 1..65535).
CNT_W, 16, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
op  in  4  opcode from the instruction register; valid from DECODE onward
zero  in  1  ALU zero flag, 1 when the compare result is equal
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until the mem_ready cycle
mem_we  out  1  write strobe, qualifies mem_req
iord  out  1  address select: 0 = PC, 1 = ALU result
ir_we  out  1  instruction register load
pc_we  out  1  PC load
pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target
regwrite  out  1  register file write
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = write-back from memory data
alusrc  out  1  1 = immediate operand
alucontrol  out  3  ADD 000, OR 001, AND 010, XOR 011, NOR 100, ROT 101, SLL 110, compare 111
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse in DECODE for opcodes 1101..1111
halted  out  1  sticky memory-timeout indication

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous and active-low. While rst_n=0 on a clock edge: state <= S_RST, wait_cnt <= 0, halted <= 0.
- Output decode: all outputs are decoded combinationally from the state register and op. In S_RST every output is 0 and alucontrol=000.
- S_RST always goes to FETCH on the next cycle.
- FETCH:
  - Drives mem_req=1, iord=0, mem_we=0.
  - On mem_ready=1: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - JMP (1011): pc_we=1, pc_src=10, instr_done=1, go to FETCH.
  - NOP (1100): instr_done=1, go to FETCH.
  - 1101..1111: illegal_op=1 and instr_done=1, go to FETCH, treated as NOP.
  - All other opcodes go to EXEC.
- EXEC (1 cycle):
  - R-type (ADD, OR, AND, XOR, NOR, SLL, ROT): alusrc=0, alucontrol per the code table, go to WB.
  - ADDI: alusrc=1, alucontrol=000, go to WB.
  - LD and ST: alusrc=1, alucontrol=000, go to MEM.
  - BNE: alucontrol=111. If zero=0, pc_we=1 and pc_src=01. instr_done=1, go to FETCH.
- MEM:
  - Drives mem_req=1, iord=1, alusrc=1, alucontrol=000; mem_we=1 for ST only.
  - On mem_ready, LD goes to WB.
  - On mem_ready, ST asserts instr_done=1 and goes to FETCH.
- WB (1 cycle):
  - regwrite=1, instr_done=1, then FETCH.
  - R-type: regdst=1, memtoreg=0.
  - ADDI: regdst=0, memtoreg=0.
  - LD: regdst=0, memtoreg=1.
- Latency with zero-wait memory (mem_ready=1 in the first request cycle), in cycles: R-type and ADDI 4, LD 5, ST 4, BNE 3, JMP 2, NOP and illegal 2. Each wait cycle adds 1.
- Handshake rules:
  - mem_ready is sampled only while mem_req=1 and is ignored in all other states.
  - mem_req, mem_we and iord stay stable from request until the mem_ready cycle inclusive.
  - The request deasserts in the cycle after mem_ready.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM.
  - wait_cnt increments on each request cycle with mem_ready=0.
  - If mem_ready=0 and wait_cnt==TIMEOUT-1, go to S_HALT.
  - mem_ready in the expiry cycle wins, and the access completes normally.
- S_HALT: halted=1 and all other outputs 0. The FSM leaves S_HALT only through reset.
- Reset mid-operation: any state, including a pending memory request, goes to S_RST on the next edge. mem_req drops in the cycle after reset is sampled, and no write-back or PC update occurs in that cycle.
- op is not latched; the IR must hold op stable from DECODE through WB (ir_we is asserted only in FETCH).

Test Plan:
- Reset, then ADD (op=0000) with mem_ready tied to 1 -> state sequence FETCH, DECODE, EXEC, WB. ir_we and pc_we pulse in cycle 1; regwrite=1 and regdst=1 in cycle 4; instr_done in cycle 4; no illegal_op.
- LD (1001) with a 3-cycle data wait (mem_ready low for 2 cycles) -> iord=1 and mem_req high for exactly 3 MEM cycles, then WB with memtoreg=1 and regwrite=1. Total 7 cycles.
- BNE (1000) with zero=0 -> pc_we=1 and pc_src=01 in EXEC. With zero=1 -> pc_we=0. Both retire in 3 cycles. JMP (1011) -> pc_src=10 in DECODE, 2 cycles.
- TIMEOUT=4, mem_ready held 0 in FETCH -> mem_req high for 4 cycles, then halted=1 permanently. A repeat run with mem_ready=1 in the 4th wait cycle -> completes normally, halted stays 0.
- op=1110 -> illegal_op pulses once in DECODE, no regwrite, pc_we or mem_req beyond the fetch, back to FETCH after 2 cycles.
- ST (1010) with mem_ready=0, then rst_n=0 for 1 cycle mid-MEM -> mem_req=0 in the cycle after reset is sampled, all outputs 0 in S_RST, FETCH resumes with mem_req=1 and iord=0.
